// File: rtl/irq_arbiter.sv
//------------------------------------------------------------------------------
// Module      : irq_arbiter
// Description : Four-source edge-triggered interrupt arbiter with a mask
//               register and a fixed-priority request/acknowledge/finish
//               handshake. Define IRQ_NESTING_EN to allow higher-priority
//               sources to preempt an interrupt that is already in service.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module irq_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] irq_in,
    input  logic       mask_we,
    input  logic [3:0] mask_in,
    input  logic       int_ack,
    input  logic       int_fin,
    output logic       int_req,
    output logic [1:0] int_id,
    output logic [3:0] pending_o,
    output logic [3:0] in_service_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t     r_state, w_nxt_state;
    logic [3:0] r_irq_prev;
    logic [3:0] r_pending, w_nxt_pending;
    logic [3:0] r_mask;
    logic [3:0] r_in_service, w_nxt_in_service;
    logic [1:0] r_int_id, w_nxt_int_id;
    logic       r_int_req;

    logic [3:0] w_edge;
    logic [3:0] w_enabled;
    logic [3:0] w_id_onehot;

    // Index 0 has the highest priority.
    function automatic logic [1:0] lowest_idx(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    assign w_edge      = irq_in & ~r_irq_prev;
    assign w_enabled   = r_pending & r_mask;
    assign w_id_onehot = 4'd1 << r_int_id;

`ifdef IRQ_NESTING_EN
    logic [1:0] w_top_isv;
    logic [3:0] w_above_isv;
    assign w_top_isv   = lowest_idx(r_in_service);
    assign w_above_isv = (4'd1 << w_top_isv) - 4'd1;
`endif

    always_comb begin
        w_nxt_state      = r_state;
        w_nxt_int_id     = r_int_id;
        w_nxt_in_service = r_in_service;
        // A fresh edge on the source being acknowledged wins over the clear.
        w_nxt_pending    = r_pending | w_edge;

        case (r_state)
            IDLE: begin
                if (w_enabled != 4'd0) begin
                    w_nxt_state  = REQ;
                    w_nxt_int_id = lowest_idx(w_enabled);
                end
            end
            REQ: begin
                if (int_ack) begin
                    w_nxt_state      = SERVICE;
                    w_nxt_pending    = (r_pending & ~w_id_onehot) | w_edge;
                    w_nxt_in_service = r_in_service | w_id_onehot;
                end
            end
            SERVICE: begin
`ifdef IRQ_NESTING_EN
                if (int_fin) begin
                    w_nxt_in_service = r_in_service & ~(r_in_service & (~r_in_service + 4'd1));
                    if (w_nxt_in_service == 4'd0) begin
                        w_nxt_state = IDLE;
                    end
                end else if ((w_enabled & w_above_isv) != 4'd0) begin
                    w_nxt_state  = REQ;
                    w_nxt_int_id = lowest_idx(w_enabled);
                end
`else
                if (int_fin && $onehot(r_in_service)) begin
                    w_nxt_in_service = 4'd0;
                    w_nxt_state      = IDLE;
                end
`endif
            end
            default: begin
                w_nxt_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        r_irq_prev <= irq_in;
        if (reset) begin
            r_state      <= IDLE;
            r_pending    <= 4'd0;
            r_mask       <= 4'd0;
            r_in_service <= 4'd0;
            r_int_id     <= 2'd0;
            r_int_req    <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_pending    <= w_nxt_pending;
            r_in_service <= w_nxt_in_service;
            r_int_id     <= w_nxt_int_id;
            r_int_req    <= (w_nxt_state == REQ);
            if (mask_we) begin
                r_mask <= mask_in;
            end
        end
    end

    assign int_req      = r_int_req;
    assign int_id       = r_int_id;
    assign pending_o    = r_pending;
    assign in_service_o = r_in_service;

endmodule

`default_nettype wire

// File: tb/tb_irq_arbiter.sv
//------------------------------------------------------------------------------
// Module      : tb_irq_arbiter
// Description : Directed self-checking bench for irq_arbiter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_irq_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] irq_in;
    logic       mask_we;
    logic [3:0] mask_in;
    logic       int_ack;
    logic       int_fin;
    logic       int_req;
    logic [1:0] int_id;
    logic [3:0] pending_o;
    logic [3:0] in_service_o;

    irq_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .irq_in       (irq_in),
        .mask_we      (mask_we),
        .mask_in      (mask_in),
        .int_ack      (int_ack),
        .int_fin      (int_fin),
        .int_req      (int_req),
        .int_id       (int_id),
        .pending_o    (pending_o),
        .in_service_o (in_service_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic       req;
        logic [1:0] id;
        logic       chk_id;
        logic [3:0] pend;
        logic [3:0] isv;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic cmp(input string tag, input string fld, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s.%s observed=%b expected=%b", tag, fld, obs, exp);
        end
    endtask

    // Push the expected post-edge outputs, advance one clock, then pop and compare.
    task automatic step(input string tag, input logic req, input logic [1:0] id,
                        input logic chk_id, input logic [3:0] pend, input logic [3:0] isv);
        exp_t e;
        e.tag = tag; e.req = req; e.id = id; e.chk_id = chk_id; e.pend = pend; e.isv = isv;
        sb.push_back(e);
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            cmp(e.tag, "int_req", {3'b0, int_req}, {3'b0, e.req});
            if (e.chk_id) cmp(e.tag, "int_id", {2'b0, int_id}, {2'b0, e.id});
            cmp(e.tag, "pending", pending_o, e.pend);
            cmp(e.tag, "in_service", in_service_o, e.isv);
        end
    endtask

    initial begin
        reset = 1'b1; irq_in = 4'd0; mask_we = 1'b0; mask_in = 4'd0;
        int_ack = 1'b0; int_fin = 1'b0;
        step("rst0", 0, 2'd0, 1, 4'b0000, 4'b0000);
        step("rst1", 0, 2'd0, 1, 4'b0000, 4'b0000);
        reset = 1'b0;

        // Basic single interrupt on source 2
        mask_we = 1'b1; mask_in = 4'b1111;
        step("mask_all", 0, 2'd0, 0, 4'b0000, 4'b0000);
        mask_we = 1'b0; irq_in = 4'b0100;
        step("b_e0", 0, 2'd0, 0, 4'b0100, 4'b0000);
        irq_in = 4'b0000;
        step("b_e1", 1, 2'd2, 1, 4'b0100, 4'b0000);
        int_ack = 1'b1;
        step("b_ack", 0, 2'd0, 0, 4'b0000, 4'b0100);
        int_ack = 1'b0;
        step("b_svc", 0, 2'd0, 0, 4'b0000, 4'b0100);
        int_fin = 1'b1;
        step("b_fin", 0, 2'd0, 0, 4'b0000, 4'b0000);
        int_fin = 1'b0;
        step("b_idle", 0, 2'd0, 0, 4'b0000, 4'b0000);

        // Masked sources stay pending; mask change selects them later
        mask_we = 1'b1; mask_in = 4'b0000;
        step("m_clr", 0, 2'd0, 0, 4'b0000, 4'b0000);
        mask_we = 1'b0; irq_in = 4'b1010;
        step("m_edges", 0, 2'd0, 0, 4'b1010, 4'b0000);
        irq_in = 4'b0000;
        step("m_hold", 0, 2'd0, 0, 4'b1010, 4'b0000);
        mask_we = 1'b1; mask_in = 4'b1000;
        step("m_wr8", 0, 2'd0, 0, 4'b1010, 4'b0000);
        mask_we = 1'b0;
        step("m_req3", 1, 2'd3, 1, 4'b1010, 4'b0000);
        mask_we = 1'b1; mask_in = 4'b1010;
        step("m_frozen", 1, 2'd3, 1, 4'b1010, 4'b0000);
        mask_we = 1'b0; int_ack = 1'b1;
        step("m_ack3", 0, 2'd0, 0, 4'b0010, 4'b1000);
        int_ack = 1'b0;
        step("m_noreq", 0, 2'd0, 0, 4'b0010, 4'b1000);
        int_fin = 1'b1;
        step("m_fin3", 0, 2'd0, 0, 4'b0010, 4'b0000);
        int_fin = 1'b0;
        step("m_req1", 1, 2'd1, 1, 4'b0010, 4'b0000);
        int_ack = 1'b1;
        step("m_ack1", 0, 2'd0, 0, 4'b0000, 4'b0010);
        int_ack = 1'b0; int_fin = 1'b1;
        step("m_fin1", 0, 2'd0, 0, 4'b0000, 4'b0000);
        int_fin = 1'b0;

        // New edge on the source being acknowledged keeps it pending
        irq_in = 4'b0010;
        step("w_e0", 0, 2'd0, 0, 4'b0010, 4'b0000);
        irq_in = 4'b0000;
        step("w_req", 1, 2'd1, 1, 4'b0010, 4'b0000);
        irq_in = 4'b0010; int_ack = 1'b1;
        step("w_ackedge", 0, 2'd0, 0, 4'b0010, 4'b0010);
        irq_in = 4'b0000; int_ack = 1'b0; int_fin = 1'b1;
        step("w_fin", 0, 2'd0, 0, 4'b0010, 4'b0000);
        int_fin = 1'b0;
        step("w_rereq", 1, 2'd1, 1, 4'b0010, 4'b0000);
        int_ack = 1'b1;
        step("w_ack2", 0, 2'd0, 0, 4'b0000, 4'b0010);
        int_ack = 1'b0; int_fin = 1'b1;
        step("w_fin2", 0, 2'd0, 0, 4'b0000, 4'b0000);
        int_fin = 1'b0;

        // Simultaneous edges on 0 and 3: fixed priority
        mask_we = 1'b1; mask_in = 4'b1111;
        step("p_mask", 0, 2'd0, 0, 4'b0000, 4'b0000);
        mask_we = 1'b0; irq_in = 4'b1001;
        step("p_edges", 0, 2'd0, 0, 4'b1001, 4'b0000);
        irq_in = 4'b0000;
        step("p_req0", 1, 2'd0, 1, 4'b1001, 4'b0000);
        int_ack = 1'b1;
        step("p_ack0", 0, 2'd0, 0, 4'b1000, 4'b0001);
        int_ack = 1'b0; int_fin = 1'b1;
        step("p_fin0", 0, 2'd0, 0, 4'b1000, 4'b0000);
        int_fin = 1'b0;
        step("p_req3", 1, 2'd3, 1, 4'b1000, 4'b0000);
        int_ack = 1'b1;
        step("p_ack3", 0, 2'd0, 0, 4'b0000, 4'b1000);
        int_ack = 1'b0; int_fin = 1'b1;
        step("p_fin3", 0, 2'd0, 0, 4'b0000, 4'b0000);
        int_fin = 1'b0;

        // Reset while requesting abandons the request; later ack ignored
        irq_in = 4'b0010;
        step("r_e0", 0, 2'd0, 0, 4'b0010, 4'b0000);
        irq_in = 4'b0000;
        step("r_req1", 1, 2'd1, 1, 4'b0010, 4'b0000);
        reset = 1'b1;
        step("r_reset", 0, 2'd0, 1, 4'b0000, 4'b0000);
        reset = 1'b0; int_ack = 1'b1;
        step("r_ackign", 0, 2'd0, 1, 4'b0000, 4'b0000);
        int_ack = 1'b0;

        // Level held high across reset release produces no edge
        irq_in = 4'b0001; reset = 1'b1;
        step("l_rst", 0, 2'd0, 1, 4'b0000, 4'b0000);
        reset = 1'b0; mask_we = 1'b1; mask_in = 4'b1111;
        step("l_rel", 0, 2'd0, 0, 4'b0000, 4'b0000);
        mask_we = 1'b0;
        step("l_hold1", 0, 2'd0, 0, 4'b0000, 4'b0000);
        step("l_hold2", 0, 2'd0, 0, 4'b0000, 4'b0000);
        irq_in = 4'b0000;

        // Mask write and edge on the same clock both take effect
        mask_we = 1'b1; mask_in = 4'b0000;
        step("s_m0", 0, 2'd0, 0, 4'b0000, 4'b0000);
        mask_in = 4'b0100; irq_in = 4'b0100;
        step("s_both", 0, 2'd0, 0, 4'b0100, 4'b0000);
        mask_we = 1'b0; irq_in = 4'b0000;
        step("s_req2", 1, 2'd2, 1, 4'b0100, 4'b0000);
        int_ack = 1'b1;
        step("s_ack", 0, 2'd0, 0, 4'b0000, 4'b0100);
        int_ack = 1'b0; int_fin = 1'b1;
        step("s_fin", 0, 2'd0, 0, 4'b0000, 4'b0000);
        int_fin = 1'b0;

`ifdef IRQ_NESTING_EN
        // Source 0 preempts source 3 in service
        mask_we = 1'b1; mask_in = 4'b1111;
        step("n_mask", 0, 2'd0, 0, 4'b0000, 4'b0000);
        mask_we = 1'b0; irq_in = 4'b1000;
        step("n_e3", 0, 2'd0, 0, 4'b1000, 4'b0000);
        irq_in = 4'b0000;
        step("n_req3", 1, 2'd3, 1, 4'b1000, 4'b0000);
        int_ack = 1'b1;
        step("n_ack3", 0, 2'd0, 0, 4'b0000, 4'b1000);
        int_ack = 1'b0; irq_in = 4'b0001;
        step("n_e0", 0, 2'd0, 0, 4'b0001, 4'b1000);
        irq_in = 4'b0000;
        step("n_req0", 1, 2'd0, 1, 4'b0001, 4'b1000);
        int_ack = 1'b1;
        step("n_ack0", 0, 2'd0, 0, 4'b0000, 4'b1001);
        int_ack = 1'b0; int_fin = 1'b1;
        step("n_fin0", 0, 2'd0, 0, 4'b0000, 4'b1000);
        int_fin = 1'b0;
        step("n_stay", 0, 2'd0, 0, 4'b0000, 4'b1000);
        int_fin = 1'b1;
        step("n_fin3", 0, 2'd0, 0, 4'b0000, 4'b0000);
        int_fin = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/irq_arbiter.md
IRQ_ARBITER -- requirements
Module: irq_arbiter

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port irq_in  input  4  external interrupt sources; index 0 highest priority.
REQ-004 SHALL have port mask_we  input  1  write strobe for mask register.
REQ-005 SHALL have port mask_in  input  4  new mask value; bit=1 enables source.
REQ-006 SHALL have port int_ack  input  1  control unit has taken the request (vector jump).
REQ-007 SHALL have port int_fin  input  1  control unit end-of-interrupt (return from ISR).
REQ-008 SHALL have port int_req  output  1  interrupt request to control unit.
REQ-009 SHALL have port int_id  output  2  index of the requested source, valid while int_req=1.
REQ-010 SHALL have port pending_o  output  4  pending register, readable via an input port.
REQ-011 SHALL have port in_service_o  output  4  in-service register.

Function
REQ-012 SHALL detect rising edges per source: edge when irq_in[i]=1 and irq_prev[i]=0 at a clock edge; irq_prev <= irq_in every cycle.
REQ-013 SHALL set pending[i] on a detected edge regardless of mask; pending holds until acknowledged.
REQ-014 SHALL apply mask_in to mask at the edge where mask_we=1; masked pending bits are retained, not cleared.
REQ-015 SHALL implement FSM states IDLE, REQ, SERVICE; int_req = (state==REQ), registered, no combinational path from inputs.
REQ-016 IDLE -> REQ when (pending & mask) != 0; int_id latched to the lowest set index of (pending & mask) at that transition.
REQ-017 int_id SHALL stay frozen throughout REQ; later mask or pending changes do not alter it.
REQ-018 REQ -> SERVICE when int_ack=1: pending[int_id] cleared, in_service[int_id] set on the same edge.
REQ-019 SERVICE -> IDLE when int_fin=1 and in_service has exactly one bit set: that bit cleared.
REQ-020 int_ack outside REQ and int_fin outside SERVICE SHALL be ignored.
REQ-021 Latency: irq_in rising seen at edge E0 -> pending set after E0 -> int_req=1 after E1 (source enabled, state IDLE).
REQ-022 Edge on source i at the same edge as ack of source i: pending[i] ends 1 (new event wins).
REQ-023 mask_we and an edge at the same edge: both take effect; arbitration at the next edge uses the new mask.
REQ-024 Without nesting, no new int_req SHALL be raised while in SERVICE.

Reset
REQ-025 While reset=1 at a clock edge: state=IDLE, pending=0, mask=0, in_service=0, int_id=0, int_req=0.
REQ-026 While reset=1: irq_prev <= irq_in, so a level already high at reset release causes no edge.
REQ-027 Reset mid-operation (REQ or SERVICE) SHALL abandon the request with no further outputs; int_fin/int_ack ignored during reset.

Configuration
REQ-028 Macro IRQ_NESTING_EN SHALL enable nested interrupts; absent, behaviour is REQ-015..REQ-024 exactly.
REQ-029 With IRQ_NESTING_EN: SERVICE -> REQ when an enabled pending source has strictly higher priority (lower index) than the highest-priority in_service bit.
REQ-030 With IRQ_NESTING_EN: int_fin clears only the highest-priority in_service bit; SERVICE -> IDLE when in_service becomes 0, else stays SERVICE.
REQ-031 With IRQ_NESTING_EN: equal or lower priority pending sources wait until in_service clears down to them.

Verification
REQ-032 Reset; mask_in=4'b1111, mask_we=1; pulse irq_in[2] at E0 -> int_req=1, int_id=2 after E1; int_ack -> pending_o=0, in_service_o=4'b0100; int_fin -> IDLE, in_service_o=0.
REQ-033 Mask=4'b0000; edges on irq_in[1],[3] -> pending_o=4'b1010, int_req stays 0; write mask=4'b1000 -> int_id=3; after ack and fin, mask=4'b1010 -> int_id=1.
REQ-034 Simultaneous edges on sources 0 and 3 with mask=4'b1111 -> int_id=0 first; after ack/fin, int_id=3 next.
REQ-035 Hold irq_in=4'b0001 high across reset release -> pending_o stays 0, int_req stays 0.
REQ-036 In REQ with int_id=1, assert reset one cycle -> all outputs 0 next cycle; following int_ack ignored.
REQ-037 IRQ_NESTING_EN: serve source 3 (SERVICE); edge on source 0 -> int_req=1, int_id=0; ack -> in_service_o=4'b1001; fin -> 4'b1000, stays SERVICE; fin -> IDLE.
